// File: rtl/uart_multichannel_if.sv
//------------------------------------------------------------------------------
// uart_multichannel_if
//
// Core-side handshake bundle for uart_multichannel.
//
// Signals (channel i occupies bit i, or bits [i*DATA_W +: DATA_W] for words):
//   tx_valid  core -> uart  transmit request
//   tx_data   core -> uart  transmit words
//   tx_ready  uart -> core  transmitter idle, word will be accepted
//   rx_valid  uart -> core  one-cycle pulse, good frame received
//   rx_data   uart -> core  last good received word
//   rx_err    uart -> core  one-cycle pulse, framing (or parity) error
//
// Modports: master = core side, slave = UART side.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_multichannel_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
);
    logic [NUM_CH-1:0]        tx_valid;
    logic [NUM_CH*DATA_W-1:0] tx_data;
    logic [NUM_CH-1:0]        tx_ready;
    logic [NUM_CH-1:0]        rx_valid;
    logic [NUM_CH*DATA_W-1:0] rx_data;
    logic [NUM_CH-1:0]        rx_err;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, rx_valid, rx_data, rx_err
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, rx_valid, rx_data, rx_err
    );
endinterface

// File: rtl/uart_multichannel.sv
//------------------------------------------------------------------------------
// uart_multichannel
//
// NUM_CH independent full-duplex UART channels sharing one baud-tick
// generator. Frame: start(0), DATA_W data bits LSB first, optional even
// parity, one stop(1).
//
// Optional feature macro: UART_PARITY_EN (even parity sent and checked).
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   bus         uart_multichannel_if.slave (tx valid/ready, rx pulses/data)
//   i_rx        serial inputs, asynchronous to i_clk
//   o_tx        serial outputs, idle high
//   i_loopback  per channel: receiver listens to own transmitter, pin held 1
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_multichannel #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int BAUD_DIV   = 27
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    uart_multichannel_if.slave      bus,
    input  logic [NUM_CH-1:0]       i_rx,
    output logic [NUM_CH-1:0]       o_tx,
    input  logic [NUM_CH-1:0]       i_loopback
);

    localparam int BD_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [BD_W-1:0]  BD_LAST  = BD_W'(BAUD_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    //--------------------------------------------------------------------------
    // Shared baud tick: one-cycle pulse each time the counter wraps.
    //--------------------------------------------------------------------------
    logic [BD_W-1:0] r_baud_cnt;
    logic            w_tick;

    assign w_tick = (r_baud_cnt == BD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_baud_cnt <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Per-channel transmitter and receiver.
    //--------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // ---------------- transmitter ----------------
        tx_state_e         r_tx_state;
        logic              r_tx_line;
        logic              r_tx_ready;
        logic [DATA_W-1:0] r_tx_shift;
        logic [OS_W-1:0]   r_tx_os;
        logic [BIT_W-1:0]  r_tx_bit;
        logic [DATA_W-1:0] w_tx_word;

        assign w_tx_word = bus.tx_data[i*DATA_W +: DATA_W];

`ifdef UART_PARITY_EN
        logic r_tx_par;
`endif

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_tx_state <= TX_IDLE;
                r_tx_line  <= 1'b1;
                r_tx_ready <= 1'b1;
                r_tx_shift <= '0;
                r_tx_os    <= '0;
                r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
                r_tx_par   <= 1'b0;
`endif
            end else begin
                case (r_tx_state)
                    TX_IDLE: begin
                        if (bus.tx_valid[i] && r_tx_ready) begin
                            r_tx_shift <= w_tx_word;
`ifdef UART_PARITY_EN
                            r_tx_par   <= ^w_tx_word;
`endif
                            r_tx_line  <= 1'b0;
                            r_tx_ready <= 1'b0;
                            r_tx_os    <= '0;
                            r_tx_bit   <= '0;
                            r_tx_state <= TX_START;
                        end
                    end
                    TX_START: begin
                        if (w_tick) begin
                            if (r_tx_os == OS_LAST) begin
                                r_tx_os    <= '0;
                                r_tx_line  <= r_tx_shift[0];
                                r_tx_state <= TX_DATA;
                            end else begin
                                r_tx_os <= r_tx_os + 1'b1;
                            end
                        end
                    end
                    TX_DATA: begin
                        if (w_tick) begin
                            if (r_tx_os == OS_LAST) begin
                                r_tx_os <= '0;
                                if (r_tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                                    r_tx_line  <= r_tx_par;
                                    r_tx_state <= TX_PARITY;
`else
                                    r_tx_line  <= 1'b1;
                                    r_tx_state <= TX_STOP;
`endif
                                end else begin
                                    // Bit 0 already on the line; present the next one.
                                    r_tx_bit   <= r_tx_bit + 1'b1;
                                    r_tx_line  <= r_tx_shift[1];
                                    r_tx_shift <= r_tx_shift >> 1;
                                end
                            end else begin
                                r_tx_os <= r_tx_os + 1'b1;
                            end
                        end
                    end
`ifdef UART_PARITY_EN
                    TX_PARITY: begin
                        if (w_tick) begin
                            if (r_tx_os == OS_LAST) begin
                                r_tx_os    <= '0;
                                r_tx_line  <= 1'b1;
                                r_tx_state <= TX_STOP;
                            end else begin
                                r_tx_os <= r_tx_os + 1'b1;
                            end
                        end
                    end
`endif
                    TX_STOP: begin
                        if (w_tick) begin
                            if (r_tx_os == OS_LAST) begin
                                r_tx_os    <= '0;
                                r_tx_ready <= 1'b1;
                                r_tx_state <= TX_IDLE;
                            end else begin
                                r_tx_os <= r_tx_os + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_tx_line  <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end
                endcase
            end
        end

        assign bus.tx_ready[i] = r_tx_ready;
        assign o_tx[i]         = i_loopback[i] ? 1'b1 : r_tx_line;

        // ---------------- receiver ----------------
        rx_state_e         r_rx_state;
        logic [1:0]        r_rx_sync;
        logic [DATA_W-1:0] r_rx_shift;
        logic [DATA_W-1:0] r_rx_data;
        logic [OS_W-1:0]   r_rx_os;
        logic [BIT_W-1:0]  r_rx_bit;
        logic              r_rx_valid;
        logic              r_rx_err;
        logic              w_rx_in;
        logic              w_rx_s;
        logic              w_par_bad;

        assign w_rx_in = i_loopback[i] ? r_tx_line : i_rx[i];
        assign w_rx_s  = r_rx_sync[1];

`ifdef UART_PARITY_EN
        logic r_rx_par_bad;
        assign w_par_bad = r_rx_par_bad;
`else
        assign w_par_bad = 1'b0;
`endif

        // The synchroniser resets to the idle-line level so leaving reset
        // never looks like a start bit.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_rx_sync <= 2'b11;
            end else begin
                r_rx_sync <= {r_rx_sync[0], w_rx_in};
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_rx_state   <= RX_IDLE;
                r_rx_shift   <= '0;
                r_rx_data    <= '0;
                r_rx_os      <= '0;
                r_rx_bit     <= '0;
                r_rx_valid   <= 1'b0;
                r_rx_err     <= 1'b0;
`ifdef UART_PARITY_EN
                r_rx_par_bad <= 1'b0;
`endif
            end else begin
                r_rx_valid <= 1'b0;
                r_rx_err   <= 1'b0;
                case (r_rx_state)
                    RX_IDLE: begin
                        if (!w_rx_s) begin
                            r_rx_os    <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (w_tick) begin
                            if (r_rx_os == OS_HALF) begin
                                // Mid start bit: a high line means the low was a glitch.
                                r_rx_os    <= '0;
                                r_rx_state <= w_rx_s ? RX_IDLE : RX_DATA;
                            end else begin
                                r_rx_os <= r_rx_os + 1'b1;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (w_tick) begin
                            if (r_rx_os == OS_LAST) begin
                                r_rx_os    <= '0;
                                r_rx_shift <= {w_rx_s, r_rx_shift[DATA_W-1:1]};
                                if (r_rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                                    r_rx_state <= RX_PARITY;
`else
                                    r_rx_state <= RX_STOP;
`endif
                                end else begin
                                    r_rx_bit <= r_rx_bit + 1'b1;
                                end
                            end else begin
                                r_rx_os <= r_rx_os + 1'b1;
                            end
                        end
                    end
`ifdef UART_PARITY_EN
                    RX_PARITY: begin
                        if (w_tick) begin
                            if (r_rx_os == OS_LAST) begin
                                r_rx_os      <= '0;
                                r_rx_par_bad <= (^r_rx_shift) ^ w_rx_s;
                                r_rx_state   <= RX_STOP;
                            end else begin
                                r_rx_os <= r_rx_os + 1'b1;
                            end
                        end
                    end
`endif
                    RX_STOP: begin
                        if (w_tick) begin
                            if (r_rx_os == OS_LAST) begin
                                r_rx_os <= '0;
                                if (w_rx_s && !w_par_bad) begin
                                    r_rx_data  <= r_rx_shift;
                                    r_rx_valid <= 1'b1;
                                    r_rx_state <= RX_IDLE;
                                end else begin
                                    r_rx_err   <= 1'b1;
                                    r_rx_state <= w_rx_s ? RX_IDLE : RX_BREAK;
                                end
                            end else begin
                                r_rx_os <= r_rx_os + 1'b1;
                            end
                        end
                    end
                    RX_BREAK: begin
                        if (w_rx_s) begin
                            r_rx_state <= RX_IDLE;
                        end
                    end
                    default: begin
                        r_rx_state <= RX_IDLE;
                    end
                endcase
            end
        end

        assign bus.rx_valid[i]                  = r_rx_valid;
        assign bus.rx_err[i]                    = r_rx_err;
        assign bus.rx_data[i*DATA_W +: DATA_W]  = r_rx_data;
    end

endmodule

// File: tb/tb_uart_multichannel.sv
//------------------------------------------------------------------------------
// tb_uart_multichannel
//
// Self-checking bench for uart_multichannel (NUM_CH=2, DATA_W=8,
// OVERSAMPLE=16, BAUD_DIV=4). Expected values come from a frame-level model:
// a sent byte arrives unchanged at the receiver it is wired to, bad frames
// leave the last good word in place, and the bench decodes serial frames
// itself from the bit period.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_multichannel;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 8;
    localparam int OVERSAMPLE = 16;
    localparam int BAUD_DIV   = 4;
    localparam int T          = OVERSAMPLE * BAUD_DIV;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 3;
`else
    localparam int FRAME_BITS = DATA_W + 2;
`endif

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] rx;
    logic [NUM_CH-1:0] tx;
    logic [NUM_CH-1:0] loopback;
    logic [NUM_CH-1:0] rx_drv;
    logic              cross_en;

    uart_multichannel_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    uart_multichannel #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .OVERSAMPLE(OVERSAMPLE),
        .BAUD_DIV  (BAUD_DIV)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus),
        .i_rx      (rx),
        .o_tx      (tx),
        .i_loopback(loopback)
    );

    // rx[1] listens to tx[0] and rx[0] to tx[1] when cross-wired.
    assign rx = cross_en ? {tx[0], tx[1]} : rx_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    //--------------------------------------------------------------------------
    // Output monitor: logs every rx_valid word, counts error pulses and
    // counts cycles where tx[0] left idle while looped back.
    //--------------------------------------------------------------------------
    int         vcnt [NUM_CH];
    int         ecnt [NUM_CH];
    int         tx0_low_lb;
    logic [7:0] rlog0 [0:255];
    logic [7:0] rlog1 [0:255];

    always @(negedge clk) begin
        if (rx_valid_bit(0)) begin
            rlog0[vcnt[0] % 256] = bus.rx_data[7:0];
            vcnt[0]++;
        end
        if (rx_valid_bit(1)) begin
            rlog1[vcnt[1] % 256] = bus.rx_data[15:8];
            vcnt[1]++;
        end
        if (bus.rx_err[0] === 1'b1) ecnt[0]++;
        if (bus.rx_err[1] === 1'b1) ecnt[1]++;
        if (loopback[0] && tx[0] !== 1'b1) tx0_low_lb++;
    end

    function automatic logic rx_valid_bit(input int ch);
        return bus.rx_valid[ch] === 1'b1;
    endfunction

    function automatic logic [7:0] logged(input int ch, input int idx);
        return (ch == 0) ? rlog0[idx % 256] : rlog1[idx % 256];
    endfunction

    //--------------------------------------------------------------------------
    // Checking
    //--------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: last good word per channel.
    logic [7:0] last_good [NUM_CH];

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    task automatic send(input logic [1:0] mask, input logic [7:0] d0, input logic [7:0] d1);
        int guard;
        guard = 0;
        @(negedge clk);
        while (((bus.tx_ready & mask) != mask) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("send_ready_wait", 32'(guard < 5000), 32'd1);
        bus.tx_data  = {d1, d0};
        bus.tx_valid = mask;
        @(negedge clk);
        bus.tx_valid = '0;
    endtask

    task automatic wait_frame();
        repeat ((FRAME_BITS + 2) * T) @(negedge clk);
    endtask

    task automatic drive_bit(input int ch, input logic val);
        rx_drv[ch] = val;
        repeat (T) @(negedge clk);
    endtask

    task automatic drive_frame(input int ch, input logic [7:0] d, input logic stop_bit);
        drive_bit(ch, 1'b0);
        for (int b = 0; b < DATA_W; b++) drive_bit(ch, d[b]);
`ifdef UART_PARITY_EN
        drive_bit(ch, ^d);
`endif
        drive_bit(ch, stop_bit);
    endtask

    // Decodes one frame from tx[ch] by sampling at mid-bit.
    task automatic decode_tx(input int ch, output logic [7:0] d, output logic ok);
        int guard;
        guard = 0;
        ok    = 1'b1;
        d     = '0;
        while (tx[ch] !== 1'b0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) ok = 1'b0;
        repeat (T / 2) @(negedge clk);
        if (tx[ch] !== 1'b0) ok = 1'b0;
        for (int b = 0; b < DATA_W; b++) begin
            repeat (T) @(negedge clk);
            d[b] = tx[ch];
        end
`ifdef UART_PARITY_EN
        repeat (T) @(negedge clk);
        if (tx[ch] !== ^d) ok = 1'b0;
`endif
        repeat (T) @(negedge clk);
        if (tx[ch] !== 1'b1) ok = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    // Main sequence
    //--------------------------------------------------------------------------
    initial begin
        int         v0, v1, e0, e1, lb0, ready_low;
        logic [7:0] d0, d1, dec;
        logic       ok;

        rst_n        = 1'b0;
        bus.tx_valid = '0;
        bus.tx_data  = '0;
        rx_drv       = '1;
        cross_en     = 1'b0;
        loopback     = '0;
        last_good[0] = '0;
        last_good[1] = '0;

        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'h3);
        check("reset_tx_ready", 32'(bus.tx_ready), 32'h3);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
        check("reset_rx_err", 32'(bus.rx_err), 32'h0);
        check("reset_rx_data", 32'(bus.rx_data), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // ---- loopback on ch0 only, 0xA5 ----
        loopback = 2'b01;
        v0 = vcnt[0]; v1 = vcnt[1]; e0 = ecnt[0]; lb0 = tx0_low_lb;
        send(2'b01, 8'hA5, 8'h00);
        ready_low = 1;
        while (bus.tx_ready[0] === 1'b0 && ready_low < 2000) begin
            @(negedge clk);
            ready_low++;
        end
        check("a5_ready_low_window", 32'(ready_low >= FRAME_BITS * T - BAUD_DIV + 1 && ready_low <= FRAME_BITS * T), 32'd1);
        repeat (3 * T) @(negedge clk);
        last_good[0] = 8'hA5;
        check("a5_valid_count", 32'(vcnt[0] - v0), 32'd1);
        check("a5_logged", 32'(logged(0, v0)), 32'hA5);
        check("a5_rx_data", 32'(bus.rx_data[7:0]), 32'(last_good[0]));
        check("a5_no_err", 32'(ecnt[0] - e0), 32'd0);
        check("a5_tx0_idle", 32'(tx0_low_lb - lb0), 32'd0);
        check("a5_ch1_quiet", 32'(vcnt[1] - v1), 32'd0);

        // ---- random simultaneous loopback on both channels ----
        loopback = 2'b11;
        for (int k = 0; k < 4; k++) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            v0 = vcnt[0]; v1 = vcnt[1];
            send(2'b11, d0, d1);
            wait_frame();
            last_good[0] = d0;
            last_good[1] = d1;
            check($sformatf("lb%0d_cnt0", k), 32'(vcnt[0] - v0), 32'd1);
            check($sformatf("lb%0d_cnt1", k), 32'(vcnt[1] - v1), 32'd1);
            check($sformatf("lb%0d_data0", k), 32'(logged(0, v0)), 32'(d0));
            check($sformatf("lb%0d_data1", k), 32'(logged(1, v1)), 32'(d1));
            check($sformatf("lb%0d_rx_data", k), 32'(bus.rx_data), 32'({last_good[1], last_good[0]}));
        end

        // ---- cross-wired channels, simultaneous accepts ----
        loopback = 2'b00;
        cross_en = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            d0 = (k == 0) ? 8'h3C : 8'($urandom);
            d1 = (k == 0) ? 8'hC3 : 8'($urandom);
            v0 = vcnt[0]; v1 = vcnt[1]; e0 = ecnt[0]; e1 = ecnt[1];
            send(2'b11, d0, d1);
            wait_frame();
            last_good[0] = d1;
            last_good[1] = d0;
            check($sformatf("x%0d_cnt0", k), 32'(vcnt[0] - v0), 32'd1);
            check($sformatf("x%0d_cnt1", k), 32'(vcnt[1] - v1), 32'd1);
            check($sformatf("x%0d_data0", k), 32'(logged(0, v0)), 32'(d1));
            check($sformatf("x%0d_data1", k), 32'(logged(1, v1)), 32'(d0));
            check($sformatf("x%0d_no_err", k), 32'((ecnt[0] - e0) + (ecnt[1] - e1)), 32'd0);
        end
        cross_en = 1'b0;
        repeat (4) @(negedge clk);

        // ---- framing error with break, then a good frame ----
        v0 = vcnt[0]; e0 = ecnt[0];
        drive_frame(0, 8'h55, 1'b0);
        repeat (3 * T) @(negedge clk);
        rx_drv[0] = 1'b1;
        repeat (2 * T) @(negedge clk);
        check("brk_err_count", 32'(ecnt[0] - e0), 32'd1);
        check("brk_no_valid", 32'(vcnt[0] - v0), 32'd0);
        check("brk_rx_data_held", 32'(bus.rx_data[7:0]), 32'(last_good[0]));
        v0 = vcnt[0]; e0 = ecnt[0];
        drive_frame(0, 8'h12, 1'b1);
        repeat (2 * T) @(negedge clk);
        last_good[0] = 8'h12;
        check("after_brk_valid", 32'(vcnt[0] - v0), 32'd1);
        check("after_brk_data", 32'(logged(0, v0)), 32'h12);
        check("after_brk_no_err", 32'(ecnt[0] - e0), 32'd0);

        // ---- 20-cycle glitch on idle rx[1] ----
        v1 = vcnt[1]; e1 = ecnt[1];
        rx_drv[1] = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv[1] = 1'b1;
        repeat (FRAME_BITS * T) @(negedge clk);
        check("glitch_no_valid", 32'(vcnt[1] - v1), 32'd0);
        check("glitch_no_err", 32'(ecnt[1] - e1), 32'd0);
        check("glitch_rx_data", 32'(bus.rx_data[15:8]), 32'(last_good[1]));

        // ---- reset in the middle of bit 4 of 0xFF on ch1 ----
        send(2'b10, 8'h00, 8'hFF);
        repeat (5 * T + T / 2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", 32'(tx), 32'h3);
        check("rst_mid_ready", 32'(bus.tx_ready), 32'h3);
        check("rst_mid_rx_data", 32'(bus.rx_data), 32'h0);
        last_good[0] = '0;
        last_good[1] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(2'b10, 8'h00, 8'h01);
        decode_tx(1, dec, ok);
        check("post_rst_frame_ok", 32'(ok), 32'd1);
        check("post_rst_data", 32'(dec), 32'h01);

        // ---- bench-decoded random frame on ch0 pin ----
        d0 = 8'($urandom);
        send(2'b01, d0, 8'h00);
        decode_tx(0, dec, ok);
        check("pin_frame_ok", 32'(ok), 32'd1);
        check("pin_data", 32'(dec), 32'(d0));
        repeat (2 * T) @(negedge clk);

`ifdef UART_PARITY_EN
        // ---- parity: good loopback frame, then a flipped parity bit ----
        loopback = 2'b01;
        v0 = vcnt[0]; e0 = ecnt[0];
        send(2'b01, 8'h07, 8'h00);
        wait_frame();
        last_good[0] = 8'h07;
        check("par_valid", 32'(vcnt[0] - v0), 32'd1);
        check("par_data", 32'(logged(0, v0)), 32'h07);
        check("par_no_err", 32'(ecnt[0] - e0), 32'd0);
        loopback = 2'b00;
        v1 = vcnt[1]; e1 = ecnt[1];
        drive_bit(1, 1'b0);
        for (int b = 0; b < DATA_W; b++) drive_bit(1, d0[b]);
        drive_bit(1, ~(^d0));
        drive_bit(1, 1'b1);
        repeat (2 * T) @(negedge clk);
        check("par_bad_err", 32'(ecnt[1] - e1), 32'd1);
        check("par_bad_no_valid", 32'(vcnt[1] - v1), 32'd0);
        check("par_bad_rx_data", 32'(bus.rx_data[15:8]), 32'(last_good[1]));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
